ssif_wb_slave: RTL and testbench



---
 rtl/ssif_wb_slave.sv | 194 +++++++++++++++++++
 tb/tb_ssif_wb_slave.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssif_wb_slave.sv
// WISHBONE responder for the SSIF bus: 8 R/W command words, 8 read-only feedback/ID words.
// Latency: ack ACK_WAIT+1 cycles after the request is presented; one idle cycle between accesses.
// Backpressure: the master is stalled by withholding ack; dropping stb before ack aborts the access.
//
// Ports:
//   wb_clk_i / wb_rst_ni          clock, asynchronous active-low reset
//   wb_cyc_i, wb_stb_i, wb_we_i   request qualifiers
//   wb_adr_i                      word address, only the low 4 bits are decoded (upper bits alias)
//   wb_dat_i, wb_sel_i            write data and byte lanes
//   wb_dat_o, wb_ack_o            registered read data and acknowledge
//   cmd_flat_o                    command words 0..7, word n at [32n+31:32n]
//   cmd_wr_o                      one-cycle write strobe per command word, high during the ack cycle
//   fb_flat_i                     feedback words 8..14, word 8+k at [32k+31:32k]
//
// Optional build macro SSIF_WR_LOCK_EN: word 7 becomes a lock; words 0..6 are writable only
// while word 7 holds 32'hA5A5_5AA5, and bit 31 of word 15 reports the lock-open state.
module ssif_wb_slave #(
  parameter int          WB_SSIF_AW = 6,
  parameter int          WB_DW      = 32,
  parameter int          ACK_WAIT   = 1,
  parameter logic [31:0] ID_VALUE   = 32'h55F1_0001
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_ni,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [WB_SSIF_AW-3:0]   wb_adr_i,
  input  logic [WB_DW-1:0]        wb_dat_i,
  input  logic [WB_DW/8-1:0]      wb_sel_i,
  input  logic                    wb_we_i,
  output logic [WB_DW-1:0]        wb_dat_o,
  output logic                    wb_ack_o,
  output logic [8*WB_DW-1:0]      cmd_flat_o,
  output logic [7:0]              cmd_wr_o,
  input  logic [7*WB_DW-1:0]      fb_flat_i
);

  localparam int               SW       = WB_DW / 8;
  localparam logic [3:0]       CNT_INIT = 4'(ACK_WAIT);
  localparam logic [WB_DW-1:0] LOCK_KEY = 32'hA5A5_5AA5;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e           state_q;
  logic [3:0]       cnt_q;
  logic             hold_q;     // blocks acceptance in the first idle cycle after ack
  logic [3:0]       adr_q;
  logic             we_q;
  logic [SW-1:0]    sel_q;
  logic [WB_DW-1:0] dat_q;
  logic [WB_DW-1:0] cmd_q [8];
  logic [WB_DW-1:0] dat_o_q;
  logic             ack_q;
  logic [7:0]       wr_q;

  logic             req;
  logic             start;
  logic             fire;
  logic [3:0]       a_word;
  logic             a_we;
  logic [SW-1:0]    a_sel;
  logic [WB_DW-1:0] a_dat;
  logic             wr_allow;
  logic [WB_DW-1:0] id_word;
  logic [WB_DW-1:0] rd_mux [8];
  logic [WB_DW-1:0] rd_d;
  logic [WB_DW-1:0] wr_word_d;
  logic             wr_en_d;
  logic [7:0]       wr_mask_d;
  logic             adr_unused;

  assign req   = wb_cyc_i & wb_stb_i;
  assign start = (state_q == S_IDLE) && req && !hold_q;

  // 'fire' marks the edge that enters ACK; the access is performed on that edge.
  assign fire = (start && (ACK_WAIT == 0)) ||
                ((state_q == S_WAIT) && req && (cnt_q == 4'd1));

  // With no wait states the access completes on the accepting edge, so the
  // live bus values are used instead of the (not yet loaded) latched copy.
  assign a_word = (state_q == S_IDLE) ? wb_adr_i[3:0] : adr_q;
  assign a_we   = (state_q == S_IDLE) ? wb_we_i       : we_q;
  assign a_sel  = (state_q == S_IDLE) ? wb_sel_i      : sel_q;
  assign a_dat  = (state_q == S_IDLE) ? wb_dat_i      : dat_q;

  // Address bits above the decoded word index simply alias.
  assign adr_unused = ^wb_adr_i;

`ifdef SSIF_WR_LOCK_EN
  logic lock_open;
  assign lock_open = (cmd_q[7] == LOCK_KEY);
  assign wr_allow  = (a_word[2:0] == 3'd7) || lock_open;
  assign id_word   = {lock_open, ID_VALUE[30:0]};
`else
  assign wr_allow  = 1'b1;
  assign id_word   = ID_VALUE;
`endif

  // Upper half of the map: feedback words 8..14, ID in slot 15.
  always_comb begin
    for (int k = 0; k < 7; k++) begin
      rd_mux[k] = fb_flat_i[k*WB_DW +: WB_DW];
    end
    rd_mux[7] = id_word;
  end

  always_comb begin
    rd_d      = a_word[3] ? rd_mux[a_word[2:0]] : cmd_q[a_word[2:0]];
    wr_en_d   = a_we && !a_word[3] && wr_allow;
    wr_mask_d = wr_en_d ? (8'd1 << a_word[2:0]) : 8'd0;
    wr_word_d = cmd_q[a_word[2:0]];
    for (int b = 0; b < SW; b++) begin
      if (a_sel[b]) begin
        wr_word_d[8*b +: 8] = a_dat[8*b +: 8];
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hold_q  <= 1'b0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      dat_o_q <= '0;
      ack_q   <= 1'b0;
      wr_q    <= '0;
      for (int n = 0; n < 8; n++) begin
        cmd_q[n] <= '0;
      end
    end else begin
      // Ack, strobes and read data are single-cycle; they fall back to 0 by default.
      ack_q   <= 1'b0;
      wr_q    <= '0;
      dat_o_q <= '0;

      case (state_q)
        S_IDLE: begin
          hold_q <= 1'b0;
          if (start) begin
            adr_q   <= wb_adr_i[3:0];
            we_q    <= wb_we_i;
            sel_q   <= wb_sel_i;
            dat_q   <= wb_dat_i;
            cnt_q   <= CNT_INIT;
            state_q <= (ACK_WAIT == 0) ? S_ACK : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == 4'd1) begin
            state_q <= S_ACK;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_ACK: begin
          state_q <= S_IDLE;
          hold_q  <= 1'b1;
          cnt_q   <= '0;
        end
        default: state_q <= S_IDLE;
      endcase

      if (fire) begin
        ack_q <= 1'b1;
        wr_q  <= wr_mask_d;
        if (wr_en_d) begin
          cmd_q[a_word[2:0]] <= wr_word_d;
        end
        if (!a_we) begin
          dat_o_q <= rd_d;
        end
      end
    end
  end

  always_comb begin
    for (int n = 0; n < 8; n++) begin
      cmd_flat_o[n*WB_DW +: WB_DW] = cmd_q[n];
    end
  end

  assign wb_dat_o = dat_o_q;
  assign wb_ack_o = ack_q;
  assign cmd_wr_o = wr_q;

endmodule

// File: tb/tb_ssif_wb_slave.sv
// Bench for ssif_wb_slave: three instances (ACK_WAIT 1, 3 and 0; the second with extra
// address bits to exercise aliasing) checked against a word-level register-map model.
module tb_ssif_wb_slave;

  localparam logic [31:0] ID_VAL = 32'h55F1_0001;
  localparam logic [31:0] KEY    = 32'hA5A5_5AA5;

  logic         clk;
  logic         rst_n [3];
  logic         cyc   [3];
  logic         stb   [3];
  logic         we    [3];
  logic [5:0]   adr   [3];
  logic [31:0]  dati  [3];
  logic [3:0]   sel   [3];
  logic [31:0]  dato  [3];
  logic         ack   [3];
  logic [255:0] cflat [3];
  logic [7:0]   cwr   [3];
  logic [223:0] fb    [3];

  // Reference state: command words per instance, expected ack latency in cycles.
  logic [31:0]  mcmd  [3][8];
  int           lat_exp [3];

  int checks;
  int errors;

  ssif_wb_slave #(.WB_SSIF_AW(6), .ACK_WAIT(1)) u_dut0 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
    .wb_adr_i(adr[0][3:0]), .wb_dat_i(dati[0]), .wb_sel_i(sel[0]), .wb_we_i(we[0]),
    .wb_dat_o(dato[0]), .wb_ack_o(ack[0]), .cmd_flat_o(cflat[0]), .cmd_wr_o(cwr[0]),
    .fb_flat_i(fb[0]));

  ssif_wb_slave #(.WB_SSIF_AW(8), .ACK_WAIT(3)) u_dut1 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
    .wb_adr_i(adr[1]), .wb_dat_i(dati[1]), .wb_sel_i(sel[1]), .wb_we_i(we[1]),
    .wb_dat_o(dato[1]), .wb_ack_o(ack[1]), .cmd_flat_o(cflat[1]), .cmd_wr_o(cwr[1]),
    .fb_flat_i(fb[1]));

  ssif_wb_slave #(.WB_SSIF_AW(6), .ACK_WAIT(0)) u_dut2 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n[2]), .wb_cyc_i(cyc[2]), .wb_stb_i(stb[2]),
    .wb_adr_i(adr[2][3:0]), .wb_dat_i(dati[2]), .wb_sel_i(sel[2]), .wb_we_i(we[2]),
    .wb_dat_o(dato[2]), .wb_ack_o(ack[2]), .cmd_flat_o(cflat[2]), .cmd_wr_o(cwr[2]),
    .fb_flat_i(fb[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit writable(int d, int word);
`ifdef SSIF_WR_LOCK_EN
    return (word == 7) || (mcmd[d][7] == KEY);
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [31:0] model_read(int d, int word);
    logic [31:0] id;
    if (word < 8) return mcmd[d][word];
    if (word < 15) return fb[d][(word-8)*32 +: 32];
    id = ID_VAL;
`ifdef SSIF_WR_LOCK_EN
    id[31] = (mcmd[d][7] == KEY);
`endif
    return id;
  endfunction

  function automatic logic [255:0] model_flat(int d);
    logic [255:0] f;
    for (int n = 0; n < 8; n++) f[n*32 +: 32] = mcmd[d][n];
    return f;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] v, logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) m = (m & ~(32'hFF << (8*b))) | (v & (32'hFF << (8*b)));
    end
    return m;
  endfunction

  // One complete access: drive, wait (bounded) for ack, compare against the model,
  // then check the bus is quiet in the following cycle.
  task automatic xfer(input int d, input bit w, input int word, input logic [3:0] s,
                      input logic [31:0] v, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic [7:0]  exp_wr;
    logic [7:0]  got_wr;
    int          lat;
    exp_rd = '0;
    exp_wr = '0;
    if (w) begin
      if (word < 8 && writable(d, word)) begin
        mcmd[d][word] = merge(mcmd[d][word], v, s);
        exp_wr = 8'd1 << word;
      end
    end else begin
      exp_rd = model_read(d, word);
    end
    @(posedge clk); #1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; dati[d] = v;
    adr[d] = 6'(word);
    if (d == 1) adr[d][5:4] = 2'($urandom_range(0, 3));
    lat = -1; rd = '0; got_wr = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ack[d]) begin
        lat = n; rd = dato[d]; got_wr = cwr[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; dati[d] = $urandom;
    chk($sformatf("latency d%0d w%0d", d, word), lat, lat_exp[d]);
    chk($sformatf("rdata d%0d w%0d we%0d", d, word, w), rd, exp_rd);
    chk($sformatf("cmd_wr d%0d w%0d", d, word), got_wr, exp_wr);
    chk($sformatf("cmd_flat d%0d w%0d", d, word), cflat[d], model_flat(d));
    @(posedge clk); #1;
    chk($sformatf("ack_clear d%0d", d), ack[d], 1'b0);
    chk($sformatf("dat_clear d%0d", d), dato[d], 32'h0);
    chk($sformatf("wr_clear d%0d", d), cwr[d], 8'h0);
  endtask

  task automatic do_reset(input int d);
    rst_n[d] = 1'b0;
    cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    for (int n = 0; n < 8; n++) mcmd[d][n] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk($sformatf("rst_ack d%0d", d), ack[d], 1'b0);
    chk($sformatf("rst_dat d%0d", d), dato[d], 32'h0);
    chk($sformatf("rst_wr d%0d", d), cwr[d], 8'h0);
    chk($sformatf("rst_cmd d%0d", d), cflat[d], 256'h0);
    rst_n[d] = 1'b1;
  endtask

  task automatic rand_run(input int d, input int count);
    logic [31:0] rd;
    int          word;
    bit          w;
    logic [3:0]  s;
    logic [31:0] v;
    for (int i = 0; i < count; i++) begin
      for (int k = 0; k < 7; k++) fb[d][k*32 +: 32] = $urandom;
      word = $urandom_range(0, 15);
      w    = 1'($urandom_range(0, 1));
      s    = 4'($urandom);
      v    = $urandom;
`ifdef SSIF_WR_LOCK_EN
      if ($urandom_range(0, 3) == 0) begin
        word = 7; w = 1'b1; s = 4'hF; v = KEY;
      end
`endif
      xfer(d, w, word, s, v, rd);
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit          saw_ack;
    bit          saw_wr;
    checks = 0;
    errors = 0;
    lat_exp[0] = 2; lat_exp[1] = 4; lat_exp[2] = 1;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; dati[d] = '0; sel[d] = '0; fb[d] = '0;
    end
    for (int d = 0; d < 3; d++) do_reset(d);

    // Reset contents: command words zero, ID word constant.
    for (int w = 0; w < 8; w++) begin
      xfer(0, 1'b0, w, 4'hF, 32'h0, rd);
      chk($sformatf("reset_read w%0d", w), rd, 32'h0);
    end
    xfer(0, 1'b0, 15, 4'h0, 32'h0, rd);
    chk("id_read", rd, 32'h55F1_0001);

`ifndef SSIF_WR_LOCK_EN
    // Byte-lane masked write.
    xfer(0, 1'b1, 3, 4'b0101, 32'hDEAD_BEEF, rd);
    chk("partial_flat", cflat[0][127:96], 32'h00AD_00EF);
    xfer(0, 1'b0, 3, 4'b0000, 32'h0, rd);
    chk("partial_read", rd, 32'h00AD_00EF);
`else
    // Lock closed: write discarded; open it, write lands; status bit set.
    xfer(0, 1'b1, 2, 4'hF, 32'h11, rd);
    xfer(0, 1'b0, 2, 4'hF, 32'h0, rd);
    chk("locked_read", rd, 32'h0);
    xfer(0, 1'b1, 7, 4'hF, KEY, rd);
    xfer(0, 1'b1, 2, 4'hF, 32'h11, rd);
    xfer(0, 1'b0, 2, 4'hF, 32'h0, rd);
    chk("unlocked_read", rd, 32'h11);
    xfer(0, 1'b0, 15, 4'hF, 32'h0, rd);
    chk("lock_status", rd, 32'hD5F1_0001);
`endif

    // Feedback word: readable, write ignored.
    fb[0][2*32 +: 32] = 32'h1234_5678;
    xfer(0, 1'b0, 10, 4'hF, 32'h0, rd);
    chk("fb_read", rd, 32'h1234_5678);
    xfer(0, 1'b1, 10, 4'hF, 32'hFFFF_FFFF, rd);
    xfer(0, 1'b0, 10, 4'hF, 32'h0, rd);
    chk("fb_reread", rd, 32'h1234_5678);

    // ACK_WAIT=3: strobe dropped during WAIT aborts silently.
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 6'd0; sel[1] = 4'hF;
    dati[1] = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    saw_ack = 1'b0; saw_wr = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (ack[1]) saw_ack = 1'b1;
      if (cwr[1] != 8'h0) saw_wr = 1'b1;
    end
    chk("abort_no_ack", saw_ack, 1'b0);
    chk("abort_no_wr", saw_wr, 1'b0);
    chk("abort_reg0", cflat[1][31:0], 32'h0);
    xfer(1, 1'b1, 0, 4'hF, 32'h0000_00A1, rd);
    rand_run(1, 50);

    // Reset during WAIT of a write to word 1.
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = 6'd1; sel[1] = 4'hF;
    dati[1] = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    for (int n = 0; n < 8; n++) mcmd[1][n] = '0;
    #1;
    chk("midrst_ack", ack[1], 1'b0);
    chk("midrst_wr", cwr[1], 8'h0);
    chk("midrst_cmd", cflat[1], 256'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
    rst_n[1] = 1'b1;
    xfer(1, 1'b0, 1, 4'hF, 32'h0, rd);
    chk("midrst_reg1", rd, 32'h0);

    // Zero wait states, then randomized traffic on the other instances.
    xfer(2, 1'b1, 5, 4'hF, 32'h0BAD_CAFE, rd);
    xfer(2, 1'b0, 5, 4'h0, 32'h0, rd);
    xfer(2, 1'b0, 15, 4'hF, 32'h0, rd);
    rand_run(2, 60);
    rand_run(0, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
